// File: rtl/nios2_debug_ocimem_ctrl.sv
// ---------------------------------------------------------------------------
// nios2_debug_ocimem_ctrl
//
// Debug monitor memory controller. Takes the JTAG data word and the ocimem
// action strobes from the debug slave and performs auto-incrementing reads
// and writes into a single-port 32-bit on-chip RAM. The same RAM port is
// shared with a CPU-side Avalon slave; debug accesses always win the port
// and a stalled CPU request is retried on the next free cycle.
//
// Ports:
//   clk, reset_n             system clock, asynchronous active-low reset
//   jdo[37:0]                JTAG data word (address, read flag, write data)
//   take_action_ocimem_a     load address, optionally start a read
//   take_action_ocimem_b     write data at the monitor address, post-increment
//   take_no_action_ocimem_a  read at the monitor address, post-increment
//   debugack                 CPU halted in debug mode (writes allowed)
//   cpu_address/read/write/writedata/readdata/waitrequest  CPU RAM slave
//   MonDReg                  debug data register
//   monitor_ready            last debug operation complete
//   monitor_error            last debug operation was rejected
// ---------------------------------------------------------------------------
module nios2_debug_ocimem_ctrl #(
    parameter int ADDR_W    = 8,
    parameter     INIT_FILE = "UNUSED"
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RD_ISSUE = 2'd1;
    localparam logic [1:0] ST_RD_DATA  = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Initialisation-file hook: vendor flows attach their RAM preload here.
    if (INIT_FILE != "UNUSED") begin : g_init_file
    end

    // Registers
    logic [1:0]        state_r;
    logic [ADDR_W-1:0] mon_a_reg_r;
    logic [31:0]       mon_d_reg_r;
    logic              wr_pending_r;
    logic [31:0]       wr_data_r;
    logic              ready_r;
    logic              error_r;
    logic              cpu_ack_r;
    logic [31:0]       ram_q_r;
    logic [31:0]       mem_r [DEPTH];

    // Next-state values
    logic [1:0]        state_nxt_s;
    logic [ADDR_W-1:0] mon_a_nxt_s;
    logic [31:0]       mon_d_nxt_s;
    logic              wr_pending_nxt_s;
    logic [31:0]       wr_data_nxt_s;
    logic              ready_nxt_s;
    logic              error_nxt_s;

    // RAM port controls
    logic              rd_issue_s;
    logic              dbg_access_s;
    logic              cpu_issue_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic              ram_we_s;
    logic [31:0]       ram_wdata_s;
    logic              ram_re_s;

    // Strobe qualification
    logic              strobe_any_s;
    logic              idle_free_s;
    logic              drop_s;

    // Only the address field, read flag and write data of jdo are meaningful.
    logic              unused_jdo_s;
    assign unused_jdo_s = ^{jdo[37:36], jdo[1:0]};

    assign MonDReg         = mon_d_reg_r;
    assign monitor_ready   = ready_r;
    assign monitor_error   = error_r;
    assign cpu_readdata    = ram_q_r;
    assign cpu_waitrequest = (cpu_read | cpu_write) & ~cpu_ack_r;

    // The pending-write cycle counts as busy: a strobe landing there would
    // race the post-increment of the monitor address.
    assign strobe_any_s = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign idle_free_s  = (state_r == ST_IDLE) & ~wr_pending_r;
    assign drop_s       = strobe_any_s & ~idle_free_s;

    // RAM port arbitration: debug write or read issue owns the port; the CPU
    // issues only when free and not in its acknowledge cycle.
    always_comb begin
        rd_issue_s   = (state_r == ST_RD_ISSUE);
        dbg_access_s = wr_pending_r | rd_issue_s;
        cpu_issue_s  = (cpu_read | cpu_write) & ~cpu_ack_r & ~dbg_access_s;
        if (dbg_access_s) begin
            ram_addr_s = mon_a_reg_r;
        end else begin
            ram_addr_s = cpu_address;
        end
        if (wr_pending_r) begin
            ram_wdata_s = wr_data_r;
        end else begin
            ram_wdata_s = cpu_writedata;
        end
        ram_we_s = wr_pending_r | (cpu_issue_s & cpu_write);
        ram_re_s = rd_issue_s | (cpu_issue_s & cpu_read);
    end

    // Debug FSM and monitor register next-state logic
    always_comb begin
        state_nxt_s      = state_r;
        mon_a_nxt_s      = mon_a_reg_r;
        mon_d_nxt_s      = mon_d_reg_r;
        wr_pending_nxt_s = 1'b0;
        wr_data_nxt_s    = wr_data_r;
        ready_nxt_s      = ready_r;
        error_nxt_s      = error_r;
        case (state_r)
            ST_IDLE: begin
                if (wr_pending_r) begin
                    // Write cycle: RAM is written this cycle at mon_a_reg_r.
                    mon_a_nxt_s = mon_a_reg_r + ADDR_INC;
                    ready_nxt_s = 1'b1;
                    error_nxt_s = error_r | drop_s;
                end else if (take_action_ocimem_a) begin
                    mon_a_nxt_s = jdo[ADDR_W+1:2];
                    error_nxt_s = 1'b0;
                    if (jdo[35]) begin
                        ready_nxt_s = 1'b0;
                        state_nxt_s = ST_RD_ISSUE;
                    end else begin
                        ready_nxt_s = 1'b1;
                    end
                end else if (take_action_ocimem_b) begin
                    if (debugack) begin
                        wr_pending_nxt_s = 1'b1;
                        wr_data_nxt_s    = jdo[34:3];
                        ready_nxt_s      = 1'b0;
                        error_nxt_s      = 1'b0;
                    end else begin
                        // Rejected write: completes at once, flagged as error.
                        ready_nxt_s = 1'b1;
                        error_nxt_s = 1'b1;
                    end
                end else if (take_no_action_ocimem_a) begin
                    ready_nxt_s = 1'b0;
                    error_nxt_s = 1'b0;
                    state_nxt_s = ST_RD_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_ISSUE: begin
                mon_a_nxt_s = mon_a_reg_r + ADDR_INC;
                error_nxt_s = error_r | drop_s;
                state_nxt_s = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                mon_d_nxt_s = ram_q_r;
                ready_nxt_s = 1'b1;
                error_nxt_s = error_r | drop_s;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Debug FSM and monitor registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            mon_a_reg_r  <= {ADDR_W{1'b0}};
            mon_d_reg_r  <= 32'd0;
            wr_pending_r <= 1'b0;
            wr_data_r    <= 32'd0;
            ready_r      <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            mon_a_reg_r  <= mon_a_nxt_s;
            mon_d_reg_r  <= mon_d_nxt_s;
            wr_pending_r <= wr_pending_nxt_s;
            wr_data_r    <= wr_data_nxt_s;
            ready_r      <= ready_nxt_s;
            error_r      <= error_nxt_s;
        end
    end

    // CPU acknowledge pulse, one cycle after the CPU access reaches the RAM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_ack_r <= 1'b0;
        end else begin
            cpu_ack_r <= cpu_issue_s;
        end
    end

    // RAM array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_r[ram_addr_s] <= ram_wdata_s;
        end
    end

    // RAM registered read data, shared by the debug path and the CPU
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_q_r <= 32'd0;
        end else if (ram_re_s) begin
            ram_q_r <= mem_r[ram_addr_s];
        end
    end

endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nios2_debug_ocimem_ctrl
//
// Directed self-checking bench for nios2_debug_ocimem_ctrl (ADDR_W = 8).
// Inputs change 1 ns after the rising edge; registered outputs are observed
// there too, combinational CPU handshakes on the falling edge.
// ---------------------------------------------------------------------------
module tb_nios2_debug_ocimem_ctrl;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic        debugack;
    logic [7:0]  cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    int n_checks = 0;
    int n_errors = 0;

    nios2_debug_ocimem_ctrl #(.ADDR_W(8), .INIT_FILE("UNUSED")) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .debugack                (debugack),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [7:0] addr, input logic rd);
        jdo = 38'd0;
        jdo[9:2] = addr;
        jdo[35] = rd;
        take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic pulse_b(input logic [31:0] data);
        jdo = 38'd0;
        jdo[34:3] = data;
        take_action_ocimem_b = 1'b1;
        step();
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic pulse_n();
        take_no_action_ocimem_a = 1'b1;
        step();
        take_no_action_ocimem_a = 1'b0;
    endtask

    // Called 1 ns after the edge that sampled the strobe (edge count 1).
    task automatic wait_ready(input string tag, input int exp_edges);
        int edges;
        edges = 1;
        while (!monitor_ready && edges < 8) begin
            step();
            edges++;
        end
        check_eq({tag, "_ready"}, {31'd0, monitor_ready}, 32'd1);
        check_eq({tag, "_latency"}, 32'(edges), 32'(exp_edges));
    endtask

    initial begin
        reset_n = 1'b0;
        jdo = 38'd0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        debugack = 1'b1;
        cpu_address = 8'd0;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        cpu_writedata = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_mondreg", MonDReg, 32'd0);
        check_eq("rst_ready", {31'd0, monitor_ready}, 32'd0);
        check_eq("rst_error", {31'd0, monitor_error}, 32'd0);
        check_eq("rst_cpu_readdata", cpu_readdata, 32'd0);
        check_eq("rst_waitreq", {31'd0, cpu_waitrequest}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Write then read back
        pulse_a(8'h10, 1'b0);
        wait_ready("load10", 1);
        pulse_b(32'hDEADBEEF);
        check_eq("wr_clears_ready", {31'd0, monitor_ready}, 32'd0);
        wait_ready("wr10", 2);
        pulse_a(8'h10, 1'b1);
        wait_ready("rd10", 3);
        check_eq("rd10_data", MonDReg, 32'hDEADBEEF);
        // Address now 0x11: a write lands there and reads back from 0x11
        pulse_b(32'h12345678);
        wait_ready("wr11", 2);
        pulse_a(8'h11, 1'b1);
        wait_ready("rd11", 3);
        check_eq("rd11_data", MonDReg, 32'h12345678);

        // Burst with wrap 0xFE, 0xFF, 0x00
        pulse_a(8'hFE, 1'b0);
        wait_ready("loadFE", 1);
        for (int i = 1; i <= 3; i++) begin
            pulse_b(32'(i));
            wait_ready("burst_wr", 2);
        end
        pulse_a(8'hFE, 1'b0);
        wait_ready("reloadFE", 1);
        for (int i = 1; i <= 3; i++) begin
            pulse_n();
            wait_ready("burst_rd", 3);
            check_eq("burst_rd_data", MonDReg, 32'(i));
        end

        // Write rejected while CPU not in debug mode
        pulse_a(8'h40, 1'b0);
        wait_ready("load40", 1);
        pulse_b(32'h11111111);
        wait_ready("wr40", 2);
        pulse_a(8'h40, 1'b0);
        wait_ready("reload40", 1);
        debugack = 1'b0;
        pulse_b(32'h99999999);
        check_eq("nodbg_ready", {31'd0, monitor_ready}, 32'd1);
        check_eq("nodbg_error", {31'd0, monitor_error}, 32'd1);
        debugack = 1'b1;
        pulse_n();
        check_eq("accept_clears_ready", {31'd0, monitor_ready}, 32'd0);
        check_eq("accept_clears_error", {31'd0, monitor_error}, 32'd0);
        wait_ready("rd40", 3);
        check_eq("rd40_unchanged", MonDReg, 32'h11111111);

        // CPU write, then debug read of the same word
        cpu_address = 8'h21;
        cpu_writedata = 32'hCAFEF00D;
        cpu_write = 1'b1;
        @(negedge clk);
        check_eq("cpu_wr_wait", {31'd0, cpu_waitrequest}, 32'd1);
        @(negedge clk);
        check_eq("cpu_wr_done", {31'd0, cpu_waitrequest}, 32'd0);
        cpu_write = 1'b0;
        step();
        pulse_a(8'h21, 1'b1);
        wait_ready("rd21", 3);
        check_eq("rd21_data", MonDReg, 32'hCAFEF00D);

        // Uncontended CPU read: one wait cycle
        cpu_address = 8'h10;
        cpu_read = 1'b1;
        @(negedge clk);
        check_eq("cpu_rd_wait", {31'd0, cpu_waitrequest}, 32'd1);
        @(negedge clk);
        check_eq("cpu_rd_done", {31'd0, cpu_waitrequest}, 32'd0);
        check_eq("cpu_rd_data", cpu_readdata, 32'hDEADBEEF);
        cpu_read = 1'b0;
        step();

        // Collision: CPU read of 0x20 during the debug write cycle to 0x20
        pulse_a(8'h20, 1'b0);
        wait_ready("load20", 1);
        pulse_b(32'h00000055);
        cpu_address = 8'h20;
        cpu_read = 1'b1;
        @(negedge clk);
        check_eq("coll_wait1", {31'd0, cpu_waitrequest}, 32'd1);
        @(negedge clk);
        check_eq("coll_wait2", {31'd0, cpu_waitrequest}, 32'd1);
        check_eq("coll_dbg_ready", {31'd0, monitor_ready}, 32'd1);
        @(negedge clk);
        check_eq("coll_wait_fall", {31'd0, cpu_waitrequest}, 32'd0);
        check_eq("coll_rd_data", cpu_readdata, 32'h00000055);
        cpu_read = 1'b0;
        step();

        // Strobe during RD_DATA is dropped and flags an error
        pulse_a(8'h10, 1'b1);
        step();
        take_no_action_ocimem_a = 1'b1;
        step();
        take_no_action_ocimem_a = 1'b0;
        check_eq("drop_ready", {31'd0, monitor_ready}, 32'd1);
        check_eq("drop_error", {31'd0, monitor_error}, 32'd1);
        check_eq("drop_rd_data", MonDReg, 32'hDEADBEEF);
        step();
        step();
        check_eq("drop_no_new_op", {31'd0, monitor_ready}, 32'd1);
        check_eq("drop_error_sticky", {31'd0, monitor_error}, 32'd1);

        // Simultaneous ocimem_a and ocimem_b: address load only
        pulse_a(8'h50, 1'b0);
        wait_ready("load50", 1);
        pulse_b(32'h0BADF00D);
        wait_ready("wr50", 2);
        jdo = 38'd0;
        jdo[9:2] = 8'h50;
        take_action_ocimem_a = 1'b1;
        take_action_ocimem_b = 1'b1;
        step();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        check_eq("both_ready", {31'd0, monitor_ready}, 32'd1);
        check_eq("both_error", {31'd0, monitor_error}, 32'd0);
        step();
        pulse_n();
        wait_ready("rd50", 3);
        check_eq("both_no_write", MonDReg, 32'h0BADF00D);

        // Reset pulsed during RD_ISSUE
        pulse_a(8'h10, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_mondreg", MonDReg, 32'd0);
        check_eq("midrst_ready", {31'd0, monitor_ready}, 32'd0);
        check_eq("midrst_error", {31'd0, monitor_error}, 32'd0);
        check_eq("midrst_cpu_readdata", cpu_readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) step();
        check_eq("midrst_idle", {31'd0, monitor_ready}, 32'd0);
        // Address register reset to 0; RAM[0x00] still holds the burst value
        pulse_n();
        wait_ready("rd00_after_rst", 3);
        check_eq("rd00_preserved", MonDReg, 32'd3);
        pulse_a(8'h10, 1'b1);
        wait_ready("rd10_after_rst", 3);
        check_eq("rd10_preserved", MonDReg, 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
